dm_cache_ctrl: RTL and testbench

Parametrised direct-mapped, read-only cache controller between a CPU-side read port and a line-wide memory refill port. It replaces the single-cycle lookup with a registered lookup and an explicit miss state machine using a req/ack refill handshake. It also adds cold-start invalidation, a flush, and saturating hit/miss statistics. It sits between the instruction/data fetch logic and the main-memory model.

---
 rtl/dm_cache_ctrl_pkg.sv | 24 ++
 rtl/dm_cache_ctrl_if.sv | 37 +++
 rtl/dm_cache_ctrl_sat_counter.sv | 26 ++
 rtl/dm_cache_ctrl.sv | 156 +++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/dm_cache_ctrl_pkg.sv
// Shared types and defaults for the direct-mapped read-only cache controller.
package dm_cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    MISS_WAIT = 2'd2
  } state_t;

  localparam int DEF_ADDR_W   = 15;
  localparam int DEF_WORD_W   = 32;
  localparam int DEF_OFFSET_W = 2;
  localparam int DEF_INDEX_W  = 10;
  localparam int DEF_CNT_W    = 14;

  function automatic int calc_tag_w(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

  function automatic int calc_line_w(input int word_w, input int offset_w);
    return word_w << offset_w;
  endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// CPU read port, line refill port and statistics of the cache controller.
interface dm_cache_ctrl_if
  import dm_cache_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WORD_W   = DEF_WORD_W,
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int CNT_W    = DEF_CNT_W
);
  localparam int LINE_W = calc_line_w(WORD_W, OFFSET_W);

  logic                   cpu_req;
  logic [ADDR_W-1:0]      cpu_addr;
  logic [WORD_W-1:0]      cpu_rdata;
  logic                   cpu_ready;
  logic                   busy;
  logic                   flush;
  logic                   mem_req;
  logic [ADDR_W-OFFSET_W-1:0] mem_addr;
  logic                   mem_ack;
  logic [LINE_W-1:0]      mem_rdata;
  logic                   clr_stats;
  logic [CNT_W-1:0]       hit_count;
  logic [CNT_W-1:0]       miss_count;

  // master: the surrounding system (CPU fetch logic plus memory model)
  modport master (
    output cpu_req, cpu_addr, flush, clr_stats, mem_ack, mem_rdata,
    input  cpu_rdata, cpu_ready, busy, mem_req, mem_addr, hit_count, miss_count
  );

  modport slave (
    input  cpu_req, cpu_addr, flush, clr_stats, mem_ack, mem_rdata,
    output cpu_rdata, cpu_ready, busy, mem_req, mem_addr, hit_count, miss_count
  );

endinterface

// File: rtl/dm_cache_ctrl_sat_counter.sv
// Saturating event counter; a clear takes priority over a coincident increment.
module sat_counter #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped read-only cache: registered tag/data lookup, req/ack line refill,
// flush of all valid bits and saturating hit/miss statistics.
module dm_cache_ctrl
  import dm_cache_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WORD_W   = DEF_WORD_W,
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int INDEX_W  = DEF_INDEX_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input logic             clk,
  input logic             rst,
  dm_cache_ctrl_if.slave  bus
);

  localparam int TAG_W  = calc_tag_w(ADDR_W, INDEX_W, OFFSET_W);
  localparam int LINE_W = calc_line_w(WORD_W, OFFSET_W);
  localparam int DEPTH  = 1 << INDEX_W;
  localparam int WORDS  = 1 << OFFSET_W;

  state_t                     state_reg;
  logic [ADDR_W-1:0]          addr_reg;
  logic [DEPTH-1:0]           valid_reg;
  logic [WORD_W-1:0]          cpu_rdata_reg;
  logic                       cpu_ready_reg;
  logic                       busy_reg;
  logic                       mem_req_reg;
  logic [ADDR_W-OFFSET_W-1:0] mem_addr_reg;

  logic [LINE_W-1:0] data_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [LINE_W-1:0] rd_line_reg;
  logic [TAG_W-1:0]  rd_tag_reg;

  logic [INDEX_W-1:0]  req_index;
  logic [INDEX_W-1:0]  addr_index;
  logic [OFFSET_W-1:0] addr_off;
  logic [TAG_W-1:0]    addr_tag;
  logic                accept;
  logic                hit;
  logic                fill;
  logic                hit_inc;
  logic                miss_inc;

  logic [WORD_W-1:0] hit_words  [WORDS];
  logic [WORD_W-1:0] fill_words [WORDS];

  assign req_index  = bus.cpu_addr[OFFSET_W +: INDEX_W];
  assign addr_index = addr_reg[OFFSET_W +: INDEX_W];
  assign addr_off   = addr_reg[OFFSET_W-1:0];
  assign addr_tag   = addr_reg[ADDR_W-1 -: TAG_W];

  assign accept   = (state_reg == IDLE) && !bus.flush && bus.cpu_req;
  assign hit      = valid_reg[addr_index] && (rd_tag_reg == addr_tag);
  assign fill     = (state_reg == MISS_WAIT) && bus.mem_ack;
  assign hit_inc  = (state_reg == LOOKUP) && hit;
  assign miss_inc = (state_reg == LOOKUP) && !hit;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_words
      assign hit_words[gi]  = rd_line_reg[gi*WORD_W +: WORD_W];
      assign fill_words[gi] = bus.mem_rdata[gi*WORD_W +: WORD_W];
    end
  endgenerate

  // Arrays are read at the acceptance edge so the LOOKUP cycle compares registered
  // RAM outputs; a refill write never coincides with an acceptance.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_mem[addr_index] <= bus.mem_rdata;
      tag_mem[addr_index]  <= addr_tag;
    end
    if (accept) begin
      rd_line_reg <= data_mem[req_index];
      rd_tag_reg  <= tag_mem[req_index];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      valid_reg     <= '0;
      cpu_rdata_reg <= '0;
      cpu_ready_reg <= 1'b0;
      busy_reg      <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_addr_reg  <= '0;
    end else begin
      cpu_ready_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.flush) begin
            valid_reg <= '0;
          end else if (bus.cpu_req) begin
            addr_reg  <= bus.cpu_addr;
            busy_reg  <= 1'b1;
            state_reg <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cpu_rdata_reg <= hit_words[addr_off];
            cpu_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end else begin
            mem_req_reg  <= 1'b1;
            mem_addr_reg <= addr_reg[ADDR_W-1:OFFSET_W];
            state_reg    <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (bus.mem_ack) begin
            valid_reg[addr_index] <= 1'b1;
            cpu_rdata_reg <= fill_words[addr_off];
            cpu_ready_reg <= 1'b1;
            mem_req_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          busy_reg    <= 1'b0;
          mem_req_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_rdata = cpu_rdata_reg;
  assign bus.cpu_ready = cpu_ready_reg;
  assign bus.busy      = busy_reg;
  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_addr  = mem_addr_reg;

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .clr   (bus.clr_stats),
    .count (bus.hit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .clr   (bus.clr_stats),
    .count (bus.miss_count)
  );

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed self-checking bench for dm_cache_ctrl (default geometry, 4-bit counters).
module tb_dm_cache_ctrl;
  import dm_cache_pkg::*;

  localparam int ADDR_W   = 15;
  localparam int WORD_W   = 32;
  localparam int OFFSET_W = 2;
  localparam int INDEX_W  = 10;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  dm_cache_ctrl_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .OFFSET_W(OFFSET_W), .CNT_W(CNT_W)) bus ();

  dm_cache_ctrl #(
    .ADDR_W(ADDR_W), .WORD_W(WORD_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] LINE_A = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
  localparam logic [127:0] LINE_B = {32'hDDDD5003, 32'hCCCC5002, 32'hBBBB5001, 32'hAAAA5000};
  localparam logic [127:0] LINE_C = {32'h33330013, 32'h22220012, 32'h11110011, 32'h00000010};
  localparam logic [127:0] LINE_D = {32'h44442003, 32'h44442002, 32'h44442001, 32'h44442000};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request accepted at the next edge; hit result visible after the following edge.
  task automatic do_hit(input logic [14:0] addr, input logic [31:0] exp);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = addr;
    tick();
    bus.cpu_req = 1'b0;
    chk("hit_busy", bus.busy, 1'b1);
    chk("hit_ready_early", bus.cpu_ready, 1'b0);
    tick();
    chk("hit_ready", bus.cpu_ready, 1'b1);
    chk("hit_rdata", bus.cpu_rdata, exp);
    chk("hit_no_memreq", bus.mem_req, 1'b0);
    tick();
    chk("hit_ready_pulse", bus.cpu_ready, 1'b0);
  endtask

  task automatic do_miss(input logic [14:0] addr, input logic [12:0] maddr,
                         input logic [127:0] line, input logic [31:0] exp, input int delay);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = addr;
    tick();
    bus.cpu_req = 1'b0;
    tick();
    chk("miss_memreq", bus.mem_req, 1'b1);
    chk("miss_memaddr", bus.mem_addr, maddr);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("miss_memreq_hold", bus.mem_req, 1'b1);
    end
    chk("miss_memaddr_hold", bus.mem_addr, maddr);
    chk("miss_ready_early", bus.cpu_ready, 1'b0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = line;
    tick();
    bus.mem_ack = 1'b0;
    chk("miss_ready", bus.cpu_ready, 1'b1);
    chk("miss_rdata", bus.cpu_rdata, exp);
    chk("miss_memreq_drop", bus.mem_req, 1'b0);
    tick();
    chk("miss_ready_pulse", bus.cpu_ready, 1'b0);
  endtask

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = '0;
    bus.flush     = 1'b0;
    bus.clr_stats = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    tick();
    tick();
    chk("rst_ready", bus.cpu_ready, 1'b0);
    chk("rst_rdata", bus.cpu_rdata, 32'h0);
    chk("rst_memreq", bus.mem_req, 1'b0);
    chk("rst_memaddr", bus.mem_addr, 13'h0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_hits", bus.hit_count, 4'd0);
    chk("rst_misses", bus.miss_count, 4'd0);
    rst = 1'b0;
    tick();

    // Cold miss, then hit on another word of the same line
    do_miss(15'h1234, 13'h048D, LINE_A, 32'hAAAA0000, 3);
    chk("cold_misses", bus.miss_count, 4'd1);
    chk("cold_hits", bus.hit_count, 4'd0);
    do_hit(15'h1236, 32'hCCCC0002);
    chk("hit1_hits", bus.hit_count, 4'd1);
    chk("hit1_misses", bus.miss_count, 4'd1);

    // Conflict eviction on index 0x8D
    do_miss(15'h5234, 13'h148D, LINE_B, 32'hAAAA5000, 1);
    do_miss(15'h1234, 13'h048D, LINE_A, 32'hAAAA0000, 0);
    chk("evict_misses", bus.miss_count, 4'd3);
    chk("evict_hits", bus.hit_count, 4'd1);

    // Flush in IDLE invalidates the filled line
    bus.flush   = 1'b1;
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 15'h1236;
    tick();
    bus.flush   = 1'b0;
    bus.cpu_req = 1'b0;
    chk("flush_ignores_req", bus.busy, 1'b0);
    do_miss(15'h1236, 13'h048D, LINE_A, 32'hCCCC0002, 2);
    chk("flush_misses", bus.miss_count, 4'd4);

    // Flush during MISS_WAIT has no effect
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 15'h0010;
    tick();
    bus.cpu_req = 1'b0;
    tick();
    chk("mwflush_memaddr", bus.mem_addr, 13'h0004);
    bus.flush = 1'b1;
    tick();
    tick();
    bus.flush     = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = LINE_C;
    tick();
    bus.mem_ack = 1'b0;
    chk("mwflush_ready", bus.cpu_ready, 1'b1);
    chk("mwflush_rdata", bus.cpu_rdata, 32'h00000010);
    tick();
    do_hit(15'h1234, 32'hAAAA0000);
    do_hit(15'h0011, 32'h11110011);
    chk("mwflush_hits", bus.hit_count, 4'd3);
    chk("mwflush_misses", bus.miss_count, 4'd5);

    // Clear, then saturate the hit counter
    bus.clr_stats = 1'b1;
    tick();
    bus.clr_stats = 1'b0;
    chk("clr_hits", bus.hit_count, 4'd0);
    chk("clr_misses", bus.miss_count, 4'd0);
    for (int i = 0; i < 20; i++) do_hit(15'h1237, 32'hDDDD0003);
    chk("sat_hits", bus.hit_count, 4'd15);
    chk("sat_misses", bus.miss_count, 4'd0);

    // Clear coincident with a hit increment
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 15'h1235;
    tick();
    bus.cpu_req   = 1'b0;
    bus.clr_stats = 1'b1;
    tick();
    bus.clr_stats = 1'b0;
    chk("clrhit_ready", bus.cpu_ready, 1'b1);
    chk("clrhit_rdata", bus.cpu_rdata, 32'hBBBB0001);
    chk("clrhit_hits", bus.hit_count, 4'd0);
    tick();

    // Reset in MISS_WAIT, stray ack afterwards, then re-read misses
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 15'h2000;
    tick();
    bus.cpu_req = 1'b0;
    tick();
    chk("rmm_memreq", bus.mem_req, 1'b1);
    rst = 1'b1;
    #1;
    chk("rmm_memreq_async", bus.mem_req, 1'b0);
    chk("rmm_busy_async", bus.busy, 1'b0);
    tick();
    rst = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = LINE_D;
    tick();
    bus.mem_ack = 1'b0;
    chk("stray_ack_ready", bus.cpu_ready, 1'b0);
    chk("stray_ack_busy", bus.busy, 1'b0);
    do_miss(15'h2000, 13'h0800, LINE_D, 32'h44442000, 1);
    chk("rmm_misses", bus.miss_count, 4'd1);
    chk("rmm_hits", bus.hit_count, 4'd0);
    do_hit(15'h2003, 32'h44442003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
